multicycle_control_fsm: RTL and testbench

- Multicycle control unit for the 16-bit processor.
- Consumes OPCODE/FUNCFIELD from the instruction register and drives every datapath control strobe, including C_IRWrite back into the instruction register.
- Moore state machine with a memory-ready handshake on fetch, load and store.
- Sits between the instruction register and the datapath muxes, ALU and register file.

---
 rtl/multicycle_control_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Moore control unit for the 16-bit multicycle processor: sequences fetch/decode/execute
// and drives every datapath strobe. Define CTRL_ILLEGAL_TRAP_EN to add the HALT trap and O_Halt.
module multicycle_control_fsm #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      OPCODE,
  input  logic [3:0]      FUNCFIELD,
  input  logic            I_MemReady,
  output logic            C_IRWrite,
  output logic            C_PCWrite,
  output logic            C_PCWriteCond,
  output logic            C_BranchNE,
  output logic            C_IorD,
  output logic            C_MemRead,
  output logic            C_MemWrite,
  output logic            C_MemtoReg,
  output logic            C_RegWrite,
  output logic            C_ALUSrcA,
  output logic [1:0]      C_ALUSrcB,
  output logic [2:0]      C_ALUOp,
  output logic [1:0]      C_PCSource,
  output logic [ST_W-1:0] O_State
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic            O_Halt
`endif
);

  typedef enum logic [ST_W-1:0] {
    INIT     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    ALU_WB   = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WB   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    HALT     = 4'd12
`endif
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_NAND = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SHL  = 3'b100;
  localparam logic [2:0] ALU_SHR  = 3'b101;
  localparam logic [2:0] ALU_SAR  = 3'b110;

  state_t state_r;
  state_t next_state_s;
  logic   shift_legal_s;

  // Only funct codes 1..3 are defined under the R-type shift opcode.
  assign shift_legal_s = (FUNCFIELD == 4'b0001) || (FUNCFIELD == 4'b0010) ||
                         (FUNCFIELD == 4'b0011);
  assign O_State = state_r;

  // State register with synchronous active-low reset that overrides any pending transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and Moore control decode (IRWrite/PCWrite are the only ready-qualified strobes).
  always_comb begin
    next_state_s  = INIT;
    C_IRWrite     = 1'b0;
    C_PCWrite     = 1'b0;
    C_PCWriteCond = 1'b0;
    C_BranchNE    = 1'b0;
    C_IorD        = 1'b0;
    C_MemRead     = 1'b0;
    C_MemWrite    = 1'b0;
    C_MemtoReg    = 1'b0;
    C_RegWrite    = 1'b0;
    C_ALUSrcA     = 1'b0;
    C_ALUSrcB     = 2'b00;
    C_ALUOp       = ALU_ADD;
    C_PCSource    = 2'b00;
`ifdef CTRL_ILLEGAL_TRAP_EN
    O_Halt        = 1'b0;
`endif
    case (state_r)
      INIT: next_state_s = FETCH;
      FETCH: begin
        C_MemRead = 1'b1;
        C_ALUSrcB = 2'b01;
        C_IRWrite = I_MemReady;
        C_PCWrite = I_MemReady;
        if (I_MemReady) begin
          next_state_s = DECODE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        C_ALUSrcB = 2'b10;
        case (OPCODE)
          4'b1000, 4'b1100, 4'b1011, 4'b1111: next_state_s = EXEC_R;
          4'b0000: begin
            if (shift_legal_s) begin
              next_state_s = EXEC_R;
            end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              next_state_s = HALT;
`else
              next_state_s = FETCH;
`endif
            end
          end
          4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b0111, 4'b0110: next_state_s = EXEC_I;
          4'b0001, 4'b0010: next_state_s = MEM_ADDR;
          4'b0100, 4'b0101: next_state_s = BRANCH;
          4'b0011:          next_state_s = JUMP;
          default:          next_state_s = FETCH;
        endcase
      end
      EXEC_R: begin
        C_ALUSrcA    = 1'b1;
        next_state_s = ALU_WB;
        case (OPCODE)
          4'b1100: C_ALUOp = ALU_SUB;
          4'b1011: C_ALUOp = ALU_NAND;
          4'b1111: C_ALUOp = ALU_OR;
          4'b0000: begin
            case (FUNCFIELD)
              4'b0001: C_ALUOp = ALU_SHL;
              4'b0010: C_ALUOp = ALU_SHR;
              4'b0011: C_ALUOp = ALU_SAR;
              default: C_ALUOp = ALU_ADD;
            endcase
          end
          default: C_ALUOp = ALU_ADD;
        endcase
      end
      EXEC_I: begin
        C_ALUSrcA    = 1'b1;
        next_state_s = ALU_WB;
        case (OPCODE)
          4'b1001: begin C_ALUSrcB = 2'b10; C_ALUOp = ALU_ADD;  end
          4'b1101: begin C_ALUSrcB = 2'b10; C_ALUOp = ALU_SUB;  end
          4'b1010: begin C_ALUSrcB = 2'b11; C_ALUOp = ALU_ADD;  end
          4'b1110: begin C_ALUSrcB = 2'b11; C_ALUOp = ALU_SUB;  end
          4'b0111: begin C_ALUSrcB = 2'b11; C_ALUOp = ALU_NAND; end
          4'b0110: begin C_ALUSrcB = 2'b11; C_ALUOp = ALU_OR;   end
          default: begin C_ALUSrcB = 2'b11; C_ALUOp = ALU_ADD;  end
        endcase
      end
      ALU_WB: begin
        C_RegWrite   = 1'b1;
        next_state_s = FETCH;
      end
      MEM_ADDR: begin
        C_ALUSrcA = 1'b1;
        C_ALUSrcB = 2'b10;
        if (OPCODE == 4'b0001) begin
          next_state_s = MEM_RD;
        end else begin
          next_state_s = MEM_WR;
        end
      end
      MEM_RD: begin
        C_MemRead = 1'b1;
        C_IorD    = 1'b1;
        if (I_MemReady) begin
          next_state_s = MEM_WB;
        end else begin
          next_state_s = MEM_RD;
        end
      end
      MEM_WB: begin
        C_RegWrite   = 1'b1;
        C_MemtoReg   = 1'b1;
        next_state_s = FETCH;
      end
      MEM_WR: begin
        C_MemWrite = 1'b1;
        C_IorD     = 1'b1;
        if (I_MemReady) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = MEM_WR;
        end
      end
      BRANCH: begin
        C_ALUSrcA     = 1'b1;
        C_ALUOp       = ALU_SUB;
        C_PCWriteCond = 1'b1;
        C_PCSource    = 2'b01;
        C_BranchNE    = OPCODE[0];
        next_state_s  = FETCH;
      end
      JUMP: begin
        C_PCWrite    = 1'b1;
        C_PCSource   = 2'b10;
        next_state_s = FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      HALT: begin
        O_Halt       = 1'b1;
        next_state_s = HALT;
      end
`endif
      default: next_state_s = INIT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-cycle expected state and control word
// are queued as stimulus is applied and compared against the DUT on the falling edge.
module tb_multicycle_control_fsm;

  localparam logic [3:0] S_INIT = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4, S_ALU_WB = 4'd5, S_MEM_ADDR = 4'd6, S_MEM_RD = 4'd7;
  localparam logic [3:0] S_MEM_WB = 4'd8, S_MEM_WR = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11;
  localparam logic [3:0] S_HALT = 4'd12;

  logic       clk;
  logic       rst_n;
  logic [3:0] OPCODE;
  logic [3:0] FUNCFIELD;
  logic       I_MemReady;
  logic       C_IRWrite, C_PCWrite, C_PCWriteCond, C_BranchNE, C_IorD, C_MemRead;
  logic       C_MemWrite, C_MemtoReg, C_RegWrite, C_ALUSrcA;
  logic [1:0] C_ALUSrcB, C_PCSource;
  logic [2:0] C_ALUOp;
  logic [3:0] O_State;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       O_Halt;
`endif

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic        halt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_err;

  multicycle_control_fsm #(.ST_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .OPCODE(OPCODE), .FUNCFIELD(FUNCFIELD),
    .I_MemReady(I_MemReady), .C_IRWrite(C_IRWrite), .C_PCWrite(C_PCWrite),
    .C_PCWriteCond(C_PCWriteCond), .C_BranchNE(C_BranchNE), .C_IorD(C_IorD),
    .C_MemRead(C_MemRead), .C_MemWrite(C_MemWrite), .C_MemtoReg(C_MemtoReg),
    .C_RegWrite(C_RegWrite), .C_ALUSrcA(C_ALUSrcA), .C_ALUSrcB(C_ALUSrcB),
    .C_ALUOp(C_ALUOp), .C_PCSource(C_PCSource), .O_State(O_State)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .O_Halt(O_Halt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference control word, field order {IRWrite,PCWrite,PCWriteCond,BranchNE,IorD,MemRead,
  // MemWrite,MemtoReg,RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[2:0],PCSource[1:0]}.
  function automatic logic [16:0] ref_ctrl(input logic [3:0] st, input logic [3:0] op,
                                           input logic [3:0] fn, input logic rdy);
    logic irw, pcw, pcc, bne, iord, mr, mw, m2r, rw, sa;
    logic [1:0] sb, pcs;
    logic [2:0] aop;
    {irw, pcw, pcc, bne, iord, mr, mw, m2r, rw, sa} = 10'b0;
    sb = 2'b00; pcs = 2'b00; aop = 3'b000;
    if (st == S_FETCH) begin
      mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy;
    end else if (st == S_DECODE) begin
      sb = 2'b10;
    end else if (st == S_EXEC_R) begin
      sa = 1'b1;
      if      (op == 4'hC) aop = 3'b001;
      else if (op == 4'hB) aop = 3'b010;
      else if (op == 4'hF) aop = 3'b011;
      else if (op == 4'h0) aop = (fn == 4'd1) ? 3'b100 : (fn == 4'd2) ? 3'b101 : 3'b110;
    end else if (st == S_EXEC_I) begin
      sa = 1'b1;
      sb = (op == 4'h9 || op == 4'hD) ? 2'b10 : 2'b11;
      if      (op == 4'h9 || op == 4'hA) aop = 3'b000;
      else if (op == 4'hD || op == 4'hE) aop = 3'b001;
      else if (op == 4'h7)               aop = 3'b010;
      else                               aop = 3'b011;
    end else if (st == S_ALU_WB) begin
      rw = 1'b1;
    end else if (st == S_MEM_ADDR) begin
      sa = 1'b1; sb = 2'b10;
    end else if (st == S_MEM_RD) begin
      mr = 1'b1; iord = 1'b1;
    end else if (st == S_MEM_WB) begin
      rw = 1'b1; m2r = 1'b1;
    end else if (st == S_MEM_WR) begin
      mw = 1'b1; iord = 1'b1;
    end else if (st == S_BRANCH) begin
      sa = 1'b1; aop = 3'b001; pcc = 1'b1; pcs = 2'b01; bne = op[0];
    end else if (st == S_JUMP) begin
      pcw = 1'b1; pcs = 2'b10;
    end
    return {irw, pcw, pcc, bne, iord, mr, mw, m2r, rw, sa, sb, aop, pcs};
  endfunction

  // One clock: apply ready, queue the expectation, compare on the falling edge, advance.
  task automatic cyc(input logic [3:0] st, input logic rdy);
    exp_t e;
    exp_t got_e;
    logic halt_s;
    I_MemReady = rdy;
    e.st   = st;
    e.ctrl = ref_ctrl(st, OPCODE, FUNCFIELD, rdy);
    e.halt = (st == S_HALT);
    sb_q.push_back(e);
    @(negedge clk);
    got_e = sb_q.pop_front();
`ifdef CTRL_ILLEGAL_TRAP_EN
    halt_s = O_Halt;
`else
    halt_s = 1'b0;
`endif
    check_value($sformatf("state@%0t", $time), {28'd0, O_State}, {28'd0, got_e.st});
    check_value($sformatf("ctrl@%0t st%0d", $time, got_e.st),
                {15'd0, C_IRWrite, C_PCWrite, C_PCWriteCond, C_BranchNE, C_IorD, C_MemRead,
                 C_MemWrite, C_MemtoReg, C_RegWrite, C_ALUSrcA, C_ALUSrcB, C_ALUOp, C_PCSource},
                {15'd0, got_e.ctrl});
    check_value($sformatf("halt@%0t", $time), {31'd0, halt_s}, {31'd0, got_e.halt});
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] instr);
    OPCODE    = instr[15:12];
    FUNCFIELD = instr[3:0];
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; I_MemReady = 1'b0;
    load(16'h8B48);
    @(posedge clk); #1;
    cyc(S_INIT, 1'b1);
    rst_n = 1'b1;
    cyc(S_INIT, 1'b1);
    // add: 4 cycles, with one fetch wait first
    cyc(S_FETCH, 1'b0);
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_EXEC_R, 1'b1); cyc(S_ALU_WB, 1'b1);
    // lw with two memory wait cycles
    load(16'h1BC9);
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_MEM_ADDR, 1'b1);
    cyc(S_MEM_RD, 1'b0); cyc(S_MEM_RD, 1'b0); cyc(S_MEM_RD, 1'b1); cyc(S_MEM_WB, 1'b1);
    // bne, be, jmp
    load(16'h5B48); cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_BRANCH, 1'b1);
    load(16'h4B48); cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_BRANCH, 1'b1);
    load(16'h3B78); cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_JUMP, 1'b1);
    // immediate forms and the remaining R-type operations
    load(16'hEBC9); cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_EXEC_I, 1'b1); cyc(S_ALU_WB, 1'b1);
    load(16'h9BC9); cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_EXEC_I, 1'b1); cyc(S_ALU_WB, 1'b1);
    load(16'h7BC9); cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_EXEC_I, 1'b1); cyc(S_ALU_WB, 1'b1);
    load(16'h6BC9); cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_EXEC_I, 1'b1); cyc(S_ALU_WB, 1'b1);
    load(16'h0B43); cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_EXEC_R, 1'b1); cyc(S_ALU_WB, 1'b1);
    load(16'h0B41); cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_EXEC_R, 1'b1); cyc(S_ALU_WB, 1'b1);
    load(16'hBB42); cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_EXEC_R, 1'b1); cyc(S_ALU_WB, 1'b1);
    // sw: reset lands while waiting in MEM_WR
    load(16'h2BC9);
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_MEM_ADDR, 1'b1);
    cyc(S_MEM_WR, 1'b0);
    rst_n = 1'b0;
    cyc(S_MEM_WR, 1'b0);
    rst_n = 1'b1;
    cyc(S_INIT, 1'b0);
    // sw completing normally: 4 cycles
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_MEM_ADDR, 1'b1); cyc(S_MEM_WR, 1'b1);
    // illegal shift funct
    load(16'h0B47);
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 11; i++) cyc(S_HALT, 1'b1);
    rst_n = 1'b0;
    cyc(S_HALT, 1'b1);
    rst_n = 1'b1;
    cyc(S_INIT, 1'b1);
`endif
    load(16'h8B48);
    cyc(S_FETCH, 1'b1); cyc(S_DECODE, 1'b1); cyc(S_EXEC_R, 1'b1); cyc(S_ALU_WB, 1'b1);
    cyc(S_FETCH, 1'b0);
    check_value("queue_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
